// File: rtl/act_lut_interp_if.sv
// Valid/ready stream bundle used for the sample input and the activation output.
// The master drives valid/data and the slave drives ready.
interface act_lut_interp_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/act_lut_interp.sv
// Two-stage activation interpolator: stage 1 registers the LUT address and fraction,
// stage 2 interpolates between the base and next LUT entries, rounds and saturates.
module act_lut_interp #(
    parameter int IN_W   = 8,
    parameter int ADDR_W = 4,
    parameter int FRAC_W = IN_W - ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    act_lut_interp_if.slave          in_s,
    act_lut_interp_if.master         out_s,
    output logic [ADDR_W-1:0]        lut_addr,
    input  logic signed [DATA_W-1:0] lut_base,
    input  logic signed [DATA_W-1:0] lut_next
);
    localparam int SUM_W = DATA_W + FRAC_W + 2;

    localparam logic [ADDR_W-1:0] LAST_POS_ADDR = {1'b0, {(ADDR_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] HALF =
        {{(SUM_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [FRAC_W-1:0]        frac_reg;
    logic                     s1_valid_reg;
    logic                     out_valid_reg;
    logic signed [DATA_W-1:0] out_data_reg;
    logic                     en;

    logic signed [DATA_W:0]   delta;
    logic signed [SUM_W-1:0]  delta_w;
    logic signed [SUM_W-1:0]  frac_w;
    logic signed [SUM_W-1:0]  base_w;
    logic signed [SUM_W-1:0]  prod;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  res;
    logic signed [DATA_W-1:0] res_sat;

    // Whole pipeline stalls only when a finished result is waiting downstream.
    assign en          = !out_valid_reg || out_s.ready;
    assign in_s.ready  = en;
    assign out_s.valid = out_valid_reg;
    assign out_s.data  = out_data_reg;

    always_comb begin
        // Segment 7 would otherwise interpolate towards the most-negative entry.
        if (lut_addr == LAST_POS_ADDR) begin
            delta = '0;
        end else begin
            delta = {lut_next[DATA_W-1], lut_next} - {lut_base[DATA_W-1], lut_base};
        end
        delta_w = {{(SUM_W-DATA_W-1){delta[DATA_W]}}, delta};
        frac_w  = {{(SUM_W-FRAC_W){1'b0}}, frac_reg};
        base_w  = {{(SUM_W-DATA_W){lut_base[DATA_W-1]}}, lut_base};
        prod    = delta_w * frac_w;
        sum     = (base_w <<< FRAC_W) + prod + HALF;
        res     = sum >>> FRAC_W;
        if (res > SAT_MAX) begin
            res_sat = SAT_MAX[DATA_W-1:0];
        end else if (res < SAT_MIN) begin
            res_sat = SAT_MIN[DATA_W-1:0];
        end else begin
            res_sat = res[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lut_addr      <= '0;
            frac_reg      <= '0;
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (en) begin
            s1_valid_reg  <= in_s.valid;
            out_valid_reg <= s1_valid_reg;
            if (in_s.valid) begin
                lut_addr <= in_s.data[IN_W-1 -: ADDR_W];
                frac_reg <= in_s.data[FRAC_W-1:0];
            end
            if (s1_valid_reg) begin
                out_data_reg <= res_sat;
            end
        end
    end
endmodule

// File: tb/tb_act_lut_interp.sv
// Scoreboard bench for act_lut_interp: a driver pushes hand-computed expectations,
// a negedge monitor pops and compares every output transfer.
module tb_act_lut_interp;
    logic              clk;
    logic              rst;
    logic [3:0]        lut_addr;
    logic signed [7:0] lut_base;
    logic signed [7:0] lut_next;
    logic signed [7:0] lut [16];

    act_lut_interp_if #(.W(8)) in_if ();
    act_lut_interp_if #(.W(8)) out_if ();

    act_lut_interp dut (
        .clk      (clk),
        .rst      (rst),
        .in_s     (in_if),
        .out_s    (out_if),
        .lut_addr (lut_addr),
        .lut_base (lut_base),
        .lut_next (lut_next)
    );

    assign lut_base = lut[lut_addr];
    assign lut_next = lut[4'(lut_addr + 4'd1)];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc   = 0;
    logic signed [7:0] exp_q[$];
    int                tx_id = 0;

    bit                tp_mode = 0;
    int                tp_pops = 0;
    int                last_pop_cyc = 0;
    bit                stall_prev = 0;
    logic [7:0]        held_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [7:0] d, input logic signed [7:0] e, input bit expect_out);
        bit acc;
        int tries = 0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        do begin
            @(negedge clk);
            acc = in_if.ready;
            @(posedge clk);
            if (acc && expect_out) exp_q.push_back(e);
            #1;
            tries++;
        end while (!acc && tries < 50);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: actual in_ready 0 required 1 for data 0x%02h", d);
        end
        in_if.valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev) begin
                check("hold_data", int'($signed(out_if.data)), int'($signed(held_data)));
                check("hold_valid", int'(out_if.valid), 1);
            end
            if (out_if.valid && !out_if.ready) check("stall_in_ready", int'(in_if.ready), 0);
            if (out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: actual %0d required none", $signed(out_if.data));
                end else begin
                    check($sformatf("out[%0d]", tx_id), int'($signed(out_if.data)), int'(exp_q.pop_front()));
                    tx_id++;
                    if (tp_mode) begin
                        if (tp_pops > 0) check("tp_gap", cyc - last_pop_cyc, 1);
                        tp_pops++;
                        last_pop_cyc = cyc;
                    end
                end
            end
            stall_prev = out_if.valid && !out_if.ready;
            held_data  = out_if.data;
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic signed [7:0] tp_exp [16];
        lut = '{8'sd0, 8'sd12, 8'sd15, 8'sd15, 8'sd15, 8'sd15, 8'sd15, 8'sd15,
                -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd12};
        tp_exp = '{8'sd0, 8'sd12, 8'sd15, 8'sd15, 8'sd15, 8'sd15, 8'sd15, 8'sd15,
                   -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd12};
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_if.valid), 0);
        check("rst_out_data", int'(out_if.data), 0);
        check("rst_lut_addr", int'(lut_addr), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rel_in_ready", int'(in_if.ready), 1);
        @(posedge clk);
        #1;

        // Single sample with latency check
        send(8'h18, 8'sd14, 1);
        @(negedge clk);
        check("lat_edge1_valid", int'(out_if.valid), 0);
        @(negedge clk);
        check("lat_edge2_valid", int'(out_if.valid), 1);
        @(posedge clk);
        #1;

        // Wrap, negative rounding, clamp
        send(8'hF8, -8'sd6, 1);
        send(8'h80, -8'sd15, 1);
        send(8'h7F, 8'sd15, 1);
        send(8'h08, 8'sd6, 1);
        repeat (4) @(posedge clk);
        #1;

        // Back-pressure mid-stream
        fork
            begin
                send(8'h00, 8'sd0, 1);
                send(8'h10, 8'sd12, 1);
                send(8'h20, 8'sd15, 1);
                send(8'h30, 8'sd15, 1);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_if.ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_if.ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;

        // Full throughput, one output per cycle
        tp_mode = 1;
        for (int i = 0; i < 16; i++) send(8'(i << 4), tp_exp[i], 1);
        repeat (4) @(posedge clk);
        #1;
        tp_mode = 0;
        check("tp_count", tp_pops, 16);

        // Asynchronous reset with two samples in flight
        send(8'h18, 8'sd0, 0);
        send(8'h28, 8'sd0, 0);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_if.valid), 0);
        check("midrst_lut_addr", int'(lut_addr), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_queue", exp_q.size(), 0);
        send(8'h18, 8'sd14, 1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_queue", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
